// File: rtl/mcpu_core_fetch_seq.sv
// Fetch sequencer: owns the fetch PC and queues completed 16-byte packets toward decode.
// Latency: a completed fetch appears at the queue head on the cycle after f2d_done; one idle cycle after reset, one bubble after a flush.
// Backpressure: decode stalls via d2fs_ready; once QDEPTH packets are queued, f_valid drops and the PC holds until a slot frees.
//
// Ports:
//   clkrst_core_clk / clkrst_core_rst_n      core clock, async active-low reset
//   pipe_flush / pipe_flush_virtpc           back-end redirect request and packet-granular target
//   f_valid / fs2f_virtpc                    fetch request and its virtual PC toward the fetch stage
//   f2d_done / f2d_out_packet / f2d_out_virtpc  fetch completion, packet data and its virtual PC
//   fs2d_valid / fs2d_packet / fs2d_virtpc   queue head toward decode
//   d2fs_ready                               decode takes the head this cycle
module mcpu_core_fetch_seq #(
    parameter logic [27:0] RESET_PC = 28'h0000000,
    parameter int          QDEPTH   = 2
) (
    input  logic         clkrst_core_clk,
    input  logic         clkrst_core_rst_n,
    input  logic         pipe_flush,
    input  logic [27:0]  pipe_flush_virtpc,
    output logic         f_valid,
    output logic [27:0]  fs2f_virtpc,
    input  logic         f2d_done,
    input  logic [127:0] f2d_out_packet,
    input  logic [27:0]  f2d_out_virtpc,
    output logic         fs2d_valid,
    output logic [127:0] fs2d_packet,
    output logic [27:0]  fs2d_virtpc,
    input  logic         d2fs_ready
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [27:0]     pc_q, pc_d;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [127:0]    mem_pkt [QDEPTH];
    logic [27:0]     mem_vpc [QDEPTH];
    logic            done_acc;
    logic            pop;

    // Only registered state and pipe_flush feed f_valid, so the fetch request
    // never depends combinationally on decode or fetch-stage handshakes.
    assign f_valid     = (state_q == ST_RUN) && (count_q < CW'(QDEPTH)) && !pipe_flush;
    assign fs2f_virtpc = pc_q;

    // A done is meaningful only against an outstanding request; f_valid already
    // folds in the flush discard.
    assign done_acc = f_valid && f2d_done;

    assign fs2d_valid  = (count_q != '0);
    assign pop         = fs2d_valid && d2fs_ready;
    assign fs2d_packet = fs2d_valid ? mem_pkt[rd_ptr_q] : '0;
    assign fs2d_virtpc = fs2d_valid ? mem_vpc[rd_ptr_q] : '0;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (pipe_flush) begin
            // A flush during BOOT behaves like one during REDIR: reload and bubble.
            state_d = ST_REDIR;
            pc_d    = pipe_flush_virtpc;
        end else begin
            if (done_acc) begin
                pc_d = pc_q + 28'd1;
            end
            case (state_q)
                ST_BOOT:  state_d = ST_RUN;
                ST_REDIR: state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Queue control. A flush empties the queue outright; a head popped in the
    // same cycle has already been consumed by decode.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (pipe_flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (done_acc) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({done_acc, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Packet storage carries no reset; the head outputs are gated by fs2d_valid.
    always_ff @(posedge clkrst_core_clk) begin
        if (done_acc) begin
            mem_pkt[wr_ptr_q] <= f2d_out_packet;
            mem_vpc[wr_ptr_q] <= f2d_out_virtpc;
        end
    end

endmodule

// File: tb/tb_mcpu_core_fetch_seq.sv
module tb_mcpu_core_fetch_seq;

    logic         clk;
    logic         rst_n;
    logic         pipe_flush;
    logic [27:0]  pipe_flush_virtpc;
    logic         f_valid;
    logic [27:0]  fs2f_virtpc;
    logic         f2d_done;
    logic [127:0] f2d_out_packet;
    logic [27:0]  f2d_out_virtpc;
    logic         fs2d_valid;
    logic [127:0] fs2d_packet;
    logic [27:0]  fs2d_virtpc;
    logic         d2fs_ready;

    // fetch-stage model: returns the packet for the requested PC unless overridden
    logic         fe_ovr;
    logic [127:0] ovr_pkt;
    logic [27:0]  ovr_vpc;

    // second instance with a reset PC near the top of the address space
    logic         w_f_valid;
    logic [27:0]  w_fs2f_virtpc;
    logic         w_fs2d_valid;
    logic [127:0] w_fs2d_packet;
    logic [27:0]  w_fs2d_virtpc;
    logic [127:0] w_f2d_out_packet;

    int checks = 0;
    int errors = 0;
    logic [155:0] exp_q[$];
    logic [155:0] sb_e;

    localparam logic [27:0] WRAP_PC [5] = '{28'hFFFFFFE, 28'hFFFFFFF, 28'h0000000, 28'h0000001, 28'h0000002};
    localparam logic [127:0] MAGIC = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;

    function automatic logic [127:0] pkt_of(input logic [27:0] v);
        return {4'hA, v, 4'hB, ~v, 4'hC, v, 4'hD, ~v};
    endfunction

    assign f2d_out_packet   = fe_ovr ? ovr_pkt : pkt_of(fs2f_virtpc);
    assign f2d_out_virtpc   = fe_ovr ? ovr_vpc : fs2f_virtpc;
    assign w_f2d_out_packet = pkt_of(w_fs2f_virtpc);

    mcpu_core_fetch_seq #(.RESET_PC(28'h0000000), .QDEPTH(2)) u_dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .pipe_flush        (pipe_flush),
        .pipe_flush_virtpc (pipe_flush_virtpc),
        .f_valid           (f_valid),
        .fs2f_virtpc       (fs2f_virtpc),
        .f2d_done          (f2d_done),
        .f2d_out_packet    (f2d_out_packet),
        .f2d_out_virtpc    (f2d_out_virtpc),
        .fs2d_valid        (fs2d_valid),
        .fs2d_packet       (fs2d_packet),
        .fs2d_virtpc       (fs2d_virtpc),
        .d2fs_ready        (d2fs_ready)
    );

    mcpu_core_fetch_seq #(.RESET_PC(28'hFFFFFFE), .QDEPTH(2)) u_wrap (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .pipe_flush        (1'b0),
        .pipe_flush_virtpc (28'h0000000),
        .f_valid           (w_f_valid),
        .fs2f_virtpc       (w_fs2f_virtpc),
        .f2d_done          (1'b1),
        .f2d_out_packet    (w_f2d_out_packet),
        .f2d_out_virtpc    (w_fs2f_virtpc),
        .fs2d_valid        (w_fs2d_valid),
        .fs2d_packet       (w_fs2d_packet),
        .fs2d_virtpc       (w_fs2d_virtpc),
        .d2fs_ready        (1'b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [27:0] v);
        exp_q.push_back({pkt_of(v), v});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_f_valid", f_valid, 1'b0);
        chk("rst_fs2d_valid", fs2d_valid, 1'b0);
        chk("rst_fs2d_packet", fs2d_packet, 128'h0);
        chk("rst_fs2d_virtpc", fs2d_virtpc, 28'h0);
        chk("rst_fs2f_virtpc", fs2f_virtpc, 28'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // scoreboard monitor: every head decode accepts must match the next expected entry
    always @(negedge clk) begin
        if (rst_n && fs2d_valid && d2fs_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got vpc %h, expected no packet", fs2d_virtpc);
            end else begin
                sb_e = exp_q.pop_front();
                if ({fs2d_packet, fs2d_virtpc} !== sb_e) begin
                    errors++;
                    $display("FAIL sb_head: got %h/%h expected %h/%h",
                             fs2d_packet, fs2d_virtpc, sb_e[155:28], sb_e[27:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        pipe_flush = 1'b0;
        pipe_flush_virtpc = '0;
        f2d_done = 1'b0;
        d2fs_ready = 1'b1;
        fe_ovr = 1'b0;
        ovr_pkt = '0;
        ovr_vpc = '0;

        // streaming: done and ready held high
        f2d_done = 1'b1;
        do_reset();
        chk("t1_boot_f_valid", f_valid, 1'b0);
        chk("t1_boot_fs2f", fs2f_virtpc, 28'h0);
        chk("wrap_boot_f_valid", w_f_valid, 1'b0);
        chk("wrap_boot_fs2f", w_fs2f_virtpc, 28'hFFFFFFE);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t1_f_valid", f_valid, 1'b1);
            chk("t1_fs2f", fs2f_virtpc, 28'(k));
            chk("t1_fs2d_valid", fs2d_valid, (k > 0) ? 1'b1 : 1'b0);
            chk("wrap_fs2f", w_fs2f_virtpc, WRAP_PC[k]);
            push_exp(28'(k));
        end
        step();
        f2d_done = 1'b0;
        step();
        chk("t1_drain_fs2d_valid", fs2d_valid, 1'b0);
        chk("t1_hold_fs2f", fs2f_virtpc, 28'h5);

        // decode stalled: queue fills to two, fetch stops on PC 2
        d2fs_ready = 1'b0;
        f2d_done = 1'b1;
        do_reset();
        step();
        chk("t2_fs2f0", fs2f_virtpc, 28'h0);
        push_exp(28'h0);
        step();
        chk("t2_fs2f1", fs2f_virtpc, 28'h1);
        push_exp(28'h1);
        step();
        chk("t2_full_f_valid", f_valid, 1'b0);
        chk("t2_full_fs2f", fs2f_virtpc, 28'h2);
        chk("t2_head0", fs2d_virtpc, 28'h0);
        step();
        chk("t2_held_f_valid", f_valid, 1'b0);
        chk("t2_held_fs2f", fs2f_virtpc, 28'h2);
        d2fs_ready = 1'b1;
        step();
        chk("t2_resume_f_valid", f_valid, 1'b1);
        chk("t2_resume_fs2f", fs2f_virtpc, 28'h2);
        chk("t2_head1", fs2d_virtpc, 28'h1);
        push_exp(28'h2);
        step();
        chk("t2_fs2f3", fs2f_virtpc, 28'h3);
        chk("t2_head2", fs2d_virtpc, 28'h2);

        // flush with a done pending: done discarded, head still consumed
        pipe_flush = 1'b1;
        pipe_flush_virtpc = 28'h0000100;
        #1;
        chk("t3_flush_f_valid", f_valid, 1'b0);
        step();
        pipe_flush = 1'b0;
        chk("t3_cleared_fs2d_valid", fs2d_valid, 1'b0);
        chk("t3_bubble_f_valid", f_valid, 1'b0);
        chk("t3_target_fs2f", fs2f_virtpc, 28'h0000100);
        step();
        chk("t3_run_f_valid", f_valid, 1'b1);
        chk("t3_run_fs2f", fs2f_virtpc, 28'h0000100);
        push_exp(28'h0000100);
        step();
        f2d_done = 1'b0;
        chk("t3_head_virtpc", fs2d_virtpc, 28'h0000100);
        chk("t3_next_fs2f", fs2f_virtpc, 28'h0000101);

        // slow fetch: request persists until a done pulse
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_stall_fs2f", fs2f_virtpc, 28'h0000101);
            chk("t5_stall_f_valid", f_valid, 1'b1);
            chk("t5_stall_no_push", fs2d_valid, 1'b0);
        end
        fe_ovr = 1'b1;
        ovr_pkt = MAGIC;
        ovr_vpc = 28'h0000101;
        f2d_done = 1'b1;
        exp_q.push_back({MAGIC, 28'h0000101});
        step();
        f2d_done = 1'b0;
        fe_ovr = 1'b0;
        chk("t5_pushed_valid", fs2d_valid, 1'b1);
        chk("t5_pushed_packet", fs2d_packet, MAGIC);
        chk("t5_next_fs2f", fs2f_virtpc, 28'h0000102);
        step();
        chk("t5_popped_valid", fs2d_valid, 1'b0);

        // async reset with the queue full
        d2fs_ready = 1'b0;
        f2d_done = 1'b1;
        step();
        step();
        chk("t6_full_valid", fs2d_valid, 1'b1);
        chk("t6_full_f_valid", f_valid, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_fs2d_valid", fs2d_valid, 1'b0);
        chk("t6_rst_f_valid", f_valid, 1'b0);
        chk("t6_rst_fs2f", fs2f_virtpc, 28'h0);
        chk("t6_rst_virtpc", fs2d_virtpc, 28'h0);
        chk("t6_rst_packet", fs2d_packet, 128'h0);

        chk("sb_all_consumed", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
